// File: rtl/pdm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_ramp_ctrl
//
// Purpose:
//   Moves a PDM modulator level from its current value to a commanded target
//   one LSB at a time. A programmable prescaler sets the step period
//   (rate+1 clock cycles). Every step produces a write strobe to the
//   modulator, and completion of a command produces a one-cycle done pulse.
//   A new command may be issued at any time; the ramp then re-aims from the
//   level currently being driven.
//
// Ports:
//   clk        in   1       single clock, all state updates on the rising edge
//   reset      in   1       synchronous, active-high reset
//   start      in   1       single-cycle command strobe (latches target/rate)
//   target     in   LVL_W   destination level, sampled only with start
//   rate       in   RATE_W  step period minus one, sampled only with start
//   hold       in   1       freezes the step prescaler while a ramp is active
//   level_out  out  LVL_W   current level, drives the modulator level input
//   level_we   out  1       high in the first cycle that shows a new level
//   busy       out  1       high while a ramp is in progress
//   done       out  1       one-cycle pulse when a command completes
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module pdm_ramp_ctrl #(
  parameter int LVL_W  = 5,
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LVL_W-1:0]  target,
  input  logic [RATE_W-1:0] rate,
  input  logic              hold,
  output logic [LVL_W-1:0]  level_out,
  output logic              level_we,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  logic [0:0]        state_reg,  state_next;
  logic [LVL_W-1:0]  level_reg,  level_next;
  logic [LVL_W-1:0]  target_reg, target_next;
  logic [RATE_W-1:0] rate_reg,   rate_next;
  logic [RATE_W-1:0] presc_reg,  presc_next;
  logic              we_reg,     we_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;

  // Helper terms for the next-state logic.
  logic              cmd_is_null;   // incoming target equals the driven level
  logic              step_due;      // prescaler has reached the step period
  logic              step_up;       // direction toward the latched target
  logic [LVL_W-1:0]  stepped_level; // level after one step toward the target

  assign cmd_is_null = (target == level_reg);
  assign step_due    = (presc_reg == rate_reg);
  assign step_up     = (target_reg > level_reg);

  // While ramping, target_reg never equals level_reg, so a single LSB move
  // toward it can neither overshoot nor wrap past either end of the range.
  assign stepped_level = step_up ? (level_reg + 1'b1) : (level_reg - 1'b1);

  always_comb begin
    state_next  = state_reg;
    level_next  = level_reg;
    target_next = target_reg;
    rate_next   = rate_reg;
    presc_next  = presc_reg;
    we_next     = 1'b0;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // hold is deliberately ignored here.
        if (start) begin
          target_next = target;
          rate_next   = rate;
          presc_next  = '0;
          if (cmd_is_null) begin
            // Nothing to move: acknowledge immediately, no write strobe.
            done_next = 1'b1;
          end else begin
            state_next = ST_RAMP;
            busy_next  = 1'b1;
          end
        end
      end

      ST_RAMP: begin
        if (start) begin
          // Retarget. A command always beats a pending step on the same
          // edge; the direction is re-derived from level_reg on later cycles
          // because step_up compares against the newly latched target.
          target_next = target;
          rate_next   = rate;
          presc_next  = '0;
          if (cmd_is_null) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else if (!hold) begin
          if (step_due) begin
            presc_next = '0;
            level_next = stepped_level;
            we_next    = 1'b1;
            if (stepped_level == target_reg) begin
              // Final step: strobe, done and idle all on the same edge.
              state_next = ST_IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
        // hold=1 with no start: prescaler frozen, no step.
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      level_reg  <= '0;
      target_reg <= '0;
      rate_reg   <= '0;
      presc_reg  <= '0;
      we_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_next;
      target_reg <= target_next;
      rate_reg   <= rate_next;
      presc_reg  <= presc_next;
      we_reg     <= we_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign level_out = level_reg;
  assign level_we  = we_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_pdm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_ramp_ctrl
//
// Directed bench for pdm_ramp_ctrl. Inputs change 1 ns after each rising
// edge; outputs are sampled at the same point, so each sample shows the
// state produced by the edge just passed.
// -----------------------------------------------------------------------------
module tb_pdm_ramp_ctrl;

  localparam int LVL_W  = 5;
  localparam int RATE_W = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [LVL_W-1:0]  target;
  logic [RATE_W-1:0] rate;
  logic              hold;
  logic [LVL_W-1:0]  level_out;
  logic              level_we;
  logic              busy;
  logic              done;

  int total;
  int bad;

  pdm_ramp_ctrl #(.LVL_W(LVL_W), .RATE_W(RATE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .target    (target),
    .rate      (rate),
    .hold      (hold),
    .level_out (level_out),
    .level_we  (level_we),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lvl, input int we, input int bsy, input int dn);
    chk({tag, ".level"}, 32'(level_out), lvl);
    chk({tag, ".we"},    32'(level_we),  we);
    chk({tag, ".busy"},  32'(busy),      bsy);
    chk({tag, ".done"},  32'(done),      dn);
  endtask

  // Single-cycle start command.
  task automatic issue(input int tgt, input int rt);
    start  = 1'b1;
    target = LVL_W'(tgt);
    rate   = RATE_W'(rt);
    tick();
    start  = 1'b0;
  endtask

  // Bounded wait for a given level; an expired bound is a failed comparison.
  task automatic wait_level(input string tag, input int lvl, input int max_cycles);
    int n;
    n = 0;
    while (level_out !== LVL_W'(lvl) && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 32'(level_out), lvl);
  endtask

  initial begin
    int we_cnt;
    int done_cnt;
    int exp_lvl;

    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    rate   = '0;
    hold   = 1'b0;

    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0);

    // Up-ramp 0->3 at rate 0, start on the first cycle after reset release.
    reset = 1'b0;
    issue(3, 0);
    chk_all("up.start", 0, 0, 1, 0);
    tick(); chk_all("up.1", 1, 1, 1, 0);
    tick(); chk_all("up.2", 2, 1, 1, 0);
    tick(); chk_all("up.3", 3, 1, 0, 1);
    tick(); chk_all("up.after", 3, 0, 0, 0);

    // Move to 5, then down-ramp 5->2 at rate 2.
    issue(5, 0);
    tick(); tick();
    chk_all("to5", 5, 1, 0, 1);
    tick();
    issue(2, 2);
    we_cnt   = 0;
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_lvl = (i < 3) ? 5 : (i < 6) ? 4 : (i < 9) ? 3 : 2;
      chk($sformatf("down.lvl%0d", i), 32'(level_out), exp_lvl);
      chk($sformatf("down.we%0d", i), 32'(level_we), (i == 3 || i == 6 || i == 9) ? 1 : 0);
      if (level_we) we_cnt++;
      if (done) done_cnt++;
    end
    chk("down.we_count", we_cnt, 3);
    chk("down.done_count", done_cnt, 1);

    // Null command at level 7; hold in IDLE must not matter.
    issue(7, 0);
    wait_level("to7", 7, 10);
    tick();
    hold = 1'b1;
    issue(7, 5);
    chk_all("null", 7, 0, 0, 1);
    tick();
    chk_all("null.after", 7, 0, 0, 0);
    hold = 1'b0;

    // Retarget: 0->20 at rate 1, redirect to 4 when level shows 6.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(20, 1);
    wait_level("rt.reach6", 6, 30);
    issue(4, 1);
    chk_all("rt.edge", 6, 0, 1, 0);
    done_cnt = 0;
    tick(); chk_all("rt.1", 6, 0, 1, 0);
    tick(); chk_all("rt.2", 5, 1, 1, 0);
    tick(); chk_all("rt.3", 5, 0, 1, 0);
    tick(); chk_all("rt.4", 4, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("rt.extra_done", done_cnt, 0);

    // Hold mid-period: 4->10 at rate 3, freeze after two prescaler counts.
    issue(10, 3);
    tick(); tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("hold.%0d", i), 4, 0, 1, 0);
    end
    hold = 1'b0;
    tick(); chk_all("hold.rel1", 4, 0, 1, 0);
    tick(); chk_all("hold.rel2", 5, 1, 1, 0);

    // Reset mid-ramp at level 9, with start and hold also asserted.
    wait_level("rst.reach9", 9, 30);
    reset = 1'b1;
    start = 1'b1;
    hold  = 1'b1;
    target = LVL_W'(25);
    tick();
    chk_all("rst.mid", 0, 0, 0, 0);
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    tick();
    chk_all("rst.after", 0, 0, 0, 0);

    // Start on a pending step edge: start wins, no step, direction reverses.
    issue(10, 0);
    tick(); chk_all("pend.1", 1, 1, 1, 0);
    issue(0, 0);
    chk_all("pend.start", 1, 0, 1, 0);
    tick(); chk_all("pend.down", 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
